systolic_skew_feeder: RTL and testbench
=======================================

# systolic_skew_feeder

Upstream feeder for the N x N systolic PE array. It buffers one A tile (N rows x K) and one B tile (K x N columns), loaded through a simple write port. On `start` it streams them into the array's left and top edges with the diagonal skew the array requires: row/column lane i is delayed i cycles. The per-row valid it drives is the `valid_in` of each row's edge PE. It sits between the operand memory and the west/north PE boundary.

## Interface
- `N`, 4, array dimension (number of row lanes and column lanes)
- `K`, 4, maximum inner dimension (buffer depth per lane)
- `DW`, 16, operand width; matches PE `a_in`/`b_in`
- `clk` input 1: single clock, all logic on rising edge
- `rst` input 1: reset, synchronous and active-high
- `wr_en` input 1: buffer write strobe
- `wr_sel` input 1: 0 = A buffer, 1 = B buffer
- `wr_lane` input clog2(N): A row index / B column index
- `wr_k` input clog2(K): inner index
- `wr_data` input DW: operand value
- `start` input 1: begin streaming (single-cycle pulse expected)
- `k_len` input clog2(K+1): inner length for this run, sampled with `start`
- `a_edge` output N*DW: lane i at bits [DW*i+DW-1 : DW*i], to row i `a_in`
- `b_edge` output N*DW: lane j likewise, to column j `b_in`
- `valid_row` output N: bit i, to row i edge PE `valid_in`
- `busy` output 1: streaming in progress
- `done` output 1: one-cycle pulse at end of stream

## Operation
- States: IDLE, STREAM, DONE.
- IDLE -> STREAM when `start`=1 and effective `k_len` >= 1.
- Effective length L = min(`k_len`, K). `k_len`=0 -> IDLE -> DONE directly, with no valid output.
- STREAM: cycle counter t runs 0 .. L+N-2, for L+N-1 cycles total. Transition to DONE after t = L+N-2.
- DONE: lasts one cycle with `done`=1, then returns to IDLE.
- At step t:
  - row lane i: `a_edge[i]` = A[i][t-i] if 0 <= t-i < L, else 0.
  - column lane j: `b_edge[j]` = B[t-j][j] under the same range rule, else 0.
  - `valid_row[i]` = 1 exactly when t-i is in range.
- Writes are accepted only in IDLE with `start`=0:
  - A[wr_lane][wr_k] or B[wr_lane][wr_k] <= `wr_data`.
  - Writes in STREAM or DONE are dropped.
  - A write coinciding with `start` is dropped; `start` has priority.
  - Out-of-range `wr_lane`/`wr_k` (non-power-of-2 N, K) are dropped.
- `start` while not in IDLE is ignored. `k_len` is captured only at the accepted `start`.
- Buffers hold their contents across runs, so one load can be streamed repeatedly.

## Timing
- All outputs are registered.
- Reset values: `a_edge`=0, `b_edge`=0, `valid_row`=0, `busy`=0, `done`=0, state IDLE, counter 0. Both buffers are cleared to 0.
- Edge E0 is the edge that samples `start`=1. Step t=0 is visible in the cycle after E0; step t is visible after edge E0+t.
- `busy`=1 in exactly the L+N-1 stream cycles.
- `done`=1 in the cycle after the last stream cycle. In that cycle the outputs are already 0.
- Case `k_len`=0: `done`=1 in the cycle after E0 and `busy` stays 0.
- Back-to-back: `start` sampled in the DONE cycle is ignored. The earliest accepted restart is the first IDLE cycle, giving a stream-to-stream gap of 2 cycles.
- Reset mid-stream: at the next edge all outputs are zero, the state is IDLE, and the buffers are cleared. No `done` is issued for the aborted run.

## Test plan
- Defaults N=K=4. Load A[i][k]=4i+k+1 and B[k][j]=16+4k+j, then `start` with `k_len`=4. Required response:
  - t=0: a lanes {1,0,0,0}, b lanes {16,0,0,0}, `valid_row`=0001.
  - t=3: a lanes {4,7,10,13}, `valid_row`=1111.
  - t=6: a lanes {0,0,0,16}, `valid_row`=1000.
  - `busy` high for 7 cycles; `done` in the 8th cycle after E0.
- `k_len`=2 with the same load: stream lasts 5 cycles. At t=1: a lanes {2,5,0,0}, `valid_row`=0011. At t=4: `valid_row`=1000 and lane 3 = 14.
- `k_len`=0 -> `done`=1 in the next cycle; `busy`=0, `valid_row`=0 throughout. `k_len`=7 -> behaves as L=4 (7 stream cycles).
- Write A[0][0]=99 during STREAM, and a second write in the same cycle as `start` -> both are dropped. The next run emits 1 at t=0.
- Assert `rst` at t=3 -> next cycle all outputs are 0 and `busy`=0, with no `done`. A new `start` with no reload -> all lanes 0 while `valid_row` follows the skew pattern.
- `start` pulsed during STREAM and in the DONE cycle -> ignored. `start` in the following IDLE cycle -> new stream, t=0 in the next cycle.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// Operand feeder for an N x N systolic array: buffers one A tile and one B tile,
// then streams them onto the west/north edges with lane i delayed by i cycles.
module systolic_skew_feeder #(
    parameter int N  = 4,
    parameter int K  = 4,
    parameter int DW = 16,
    localparam int LW  = (N > 1) ? $clog2(N) : 1,
    localparam int KW  = (K > 1) ? $clog2(K) : 1,
    localparam int KLW = $clog2(K + 1),
    localparam int TW  = $clog2(K + N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [LW-1:0]   wr_lane,
    input  logic [KW-1:0]   wr_k,
    input  logic [DW-1:0]   wr_data,
    input  logic            start,
    input  logic [KLW-1:0]  k_len,
    output logic [N*DW-1:0] a_edge,
    output logic [N*DW-1:0] b_edge,
    output logic [N-1:0]    valid_row,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic [KLW-1:0]  len_q, len_d;

    // A is indexed [row][k], B is indexed [column][k] so both lanes read alike.
    logic [DW-1:0]   a_mem_q [N][K];
    logic [DW-1:0]   a_mem_d [N][K];
    logic [DW-1:0]   b_mem_q [N][K];
    logic [DW-1:0]   b_mem_d [N][K];

    logic [N*DW-1:0] a_edge_q, a_edge_d;
    logic [N*DW-1:0] b_edge_q, b_edge_d;
    logic [N-1:0]    valid_row_q, valid_row_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    int              step_k;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        len_d   = len_q;
        a_mem_d = a_mem_q;
        b_mem_d = b_mem_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (k_len == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = STREAM;
                        t_d     = '0;
                        len_d   = (int'(k_len) > K) ? KLW'(K) : k_len;
                    end
                end else if (wr_en && int'(wr_lane) < N && int'(wr_k) < K) begin
                    if (wr_sel)
                        b_mem_d[wr_lane][wr_k] = wr_data;
                    else
                        a_mem_d[wr_lane][wr_k] = wr_data;
                end
            end
            STREAM: begin
                if (int'(t_q) == int'(len_q) + N - 2) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == STREAM);

        // Outputs are precomputed for the step the registers will show next cycle.
        a_edge_d    = '0;
        b_edge_d    = '0;
        valid_row_d = '0;
        step_k      = 0;
        for (int i = 0; i < N; i++) begin
            step_k = int'(t_d) - i;
            if (busy_d && step_k >= 0 && step_k < int'(len_d)) begin
                valid_row_d[i]       = 1'b1;
                a_edge_d[DW*i +: DW] = a_mem_q[i][KW'(step_k)];
                b_edge_d[DW*i +: DW] = b_mem_q[i][KW'(step_k)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            t_q         <= '0;
            len_q       <= '0;
            a_edge_q    <= '0;
            b_edge_q    <= '0;
            valid_row_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < K; k++) begin
                    a_mem_q[i][k] <= '0;
                    b_mem_q[i][k] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            len_q       <= len_d;
            a_edge_q    <= a_edge_d;
            b_edge_q    <= b_edge_d;
            valid_row_q <= valid_row_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            a_mem_q     <= a_mem_d;
            b_mem_q     <= b_mem_d;
        end
    end

    assign a_edge    = a_edge_q;
    assign b_edge    = b_edge_q;
    assign valid_row = valid_row_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: loads A/B tiles, streams them with
// several k_len values and checks skew, write dropping, reset abort and restarts.
module tb_systolic_skew_feeder;

    localparam int N  = 4;
    localparam int K  = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic          wr_sel;
    logic [1:0]    wr_lane;
    logic [1:0]    wr_k;
    logic [15:0]   wr_data;
    logic          start;
    logic [2:0]    k_len;
    logic [63:0]   a_edge;
    logic [63:0]   b_edge;
    logic [3:0]    valid_row;
    logic          busy;
    logic          done;

    int n_compared = 0;
    int n_mismatch = 0;

    systolic_skew_feeder #(.N(N), .K(K), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_lane   (wr_lane),
        .wr_k      (wr_k),
        .wr_data   (wr_data),
        .start     (start),
        .k_len     (k_len),
        .a_edge    (a_edge),
        .b_edge    (b_edge),
        .valid_row (valid_row),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatch++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic sel, input int lane, input int k,
                                 input int data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_lane = 2'(lane);
        wr_k    = 2'(k);
        wr_data = 16'(data);
        tick();
        wr_en   = 1'b0;
    endtask

    function automatic logic [63:0] pack4(input int l0, input int l1,
                                          input int l2, input int l3);
        logic [63:0] r;
        r = {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
        return r;
    endfunction

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " a_edge"}, a_edge, 64'h0);
        checkOutput({tag, " b_edge"}, b_edge, 64'h0);
        checkOutput({tag, " valid_row"}, {60'h0, valid_row}, 64'h0);
        checkOutput({tag, " busy"}, {63'h0, busy}, 64'h0);
    endtask

    // Full run against the load A[i][k]=4i+k+1, B[k][j]=16+4k+j (all zero when cleared).
    task automatic runCheck(input int kl, input int len, input bit cleared);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [3:0]  ev;
        start = 1'b1;
        k_len = 3'(kl);
        tick();
        start = 1'b0;
        for (int t = 0; t < len + N - 1; t++) begin
            ea = '0;
            eb = '0;
            ev = '0;
            for (int i = 0; i < N; i++) begin
                if (t - i >= 0 && t - i < len) begin
                    ev[i] = 1'b1;
                    if (!cleared) begin
                        ea[16*i +: 16] = 16'(4*i + (t - i) + 1);
                        eb[16*i +: 16] = 16'(16 + 4*(t - i) + i);
                    end
                end
            end
            checkOutput($sformatf("kl%0d t%0d a_edge", kl, t), a_edge, ea);
            checkOutput($sformatf("kl%0d t%0d b_edge", kl, t), b_edge, eb);
            checkOutput($sformatf("kl%0d t%0d valid_row", kl, t), {60'h0, valid_row}, {60'h0, ev});
            checkOutput($sformatf("kl%0d t%0d busy", kl, t), {63'h0, busy}, 64'h1);
            checkOutput($sformatf("kl%0d t%0d done", kl, t), {63'h0, done}, 64'h0);
            tick();
        end
        checkOutput($sformatf("kl%0d done pulse", kl), {63'h0, done}, 64'h1);
        checkIdleOutputs($sformatf("kl%0d done cycle", kl));
        tick();
        checkOutput($sformatf("kl%0d done cleared", kl), {63'h0, done}, 64'h0);
    endtask

    task automatic waitDone(input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (done) seen = 1'b1;
            else tick();
        end
        checkOutput({tag, " done within bound"}, {63'h0, seen}, 64'h1);
        tick();
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_lane = '0;
        wr_k    = '0;
        wr_data = '0;
        start   = 1'b0;
        k_len   = '0;
        tick();
        tick();
        checkIdleOutputs("reset");
        checkOutput("reset done", {63'h0, done}, 64'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < K; k++) begin
                applyStimulus(1'b0, i, k, 4*i + k + 1);
                applyStimulus(1'b1, i, k, 16 + 4*k + i);
            end
        end

        $display("[TB] full-length run, k_len=4");
        runCheck(4, 4, 1'b0);

        $display("[TB] short run, k_len=2");
        runCheck(2, 2, 1'b0);

        $display("[TB] zero-length run");
        start = 1'b1;
        k_len = 3'd0;
        tick();
        start = 1'b0;
        checkOutput("kl0 done", {63'h0, done}, 64'h1);
        checkIdleOutputs("kl0 first");
        tick();
        checkOutput("kl0 done cleared", {63'h0, done}, 64'h0);
        checkIdleOutputs("kl0 second");

        $display("[TB] oversized k_len=7 clamps to 4");
        runCheck(7, 4, 1'b0);

        $display("[TB] writes during start and stream are dropped");
        start   = 1'b1;
        k_len   = 3'd1;
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_lane = 2'd0;
        wr_k    = 2'd0;
        wr_data = 16'd55;
        tick();
        start   = 1'b0;
        wr_data = 16'd99;
        tick();
        wr_en   = 1'b0;
        waitDone("drop-write run");
        runCheck(4, 4, 1'b0);

        $display("[TB] start ignored in STREAM and DONE");
        start = 1'b1;
        k_len = 3'd4;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        k_len = 3'd1;
        tick();
        start = 1'b0;
        checkOutput("ignored start t2 valid", {60'h0, valid_row}, 64'h7);
        tick();
        tick();
        checkOutput("ignored start t4 valid", {60'h0, valid_row}, 64'he);
        tick();
        tick();
        checkOutput("ignored start t6 valid", {60'h0, valid_row}, 64'h8);
        tick();
        checkOutput("ignored start done", {63'h0, done}, 64'h1);
        start = 1'b1;
        k_len = 3'd4;
        tick();
        start = 1'b0;
        checkOutput("start in DONE ignored busy", {63'h0, busy}, 64'h0);
        checkOutput("start in DONE ignored done", {63'h0, done}, 64'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("restart t0 busy", {63'h0, busy}, 64'h1);
        checkOutput("restart t0 a_edge", a_edge, pack4(1, 0, 0, 0));
        checkOutput("restart t0 valid", {60'h0, valid_row}, 64'h1);
        waitDone("restart run");

        $display("[TB] reset mid-stream");
        start = 1'b1;
        k_len = 3'd4;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("pre-reset t3 a_edge", a_edge, pack4(4, 7, 10, 13));
        checkOutput("pre-reset t3 valid", {60'h0, valid_row}, 64'hf);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkIdleOutputs("mid reset");
        checkOutput("mid reset done", {63'h0, done}, 64'h0);
        for (int c = 0; c < 6; c++) begin
            tick();
            checkOutput($sformatf("post reset no done c%0d", c), {63'h0, done}, 64'h0);
        end
        runCheck(4, 4, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
